// File: rtl/mem_stage_hs.sv
// MEM stage with a split-transaction data bus: waits for data_ok, holds the response while WB stalls, drops orphaned responses.
// Define MS_PERF_CNT_EN to enable the WAIT stall-cycle counter on ms_stall_cnt (tied to zero otherwise).
module mem_stage_hs #(
    parameter int PAYLOAD_W = 136,
    parameter int CANCEL_W  = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 es_to_ms_valid,
    output logic                 ms_allowin,
    input  logic [PAYLOAD_W-1:0] es_payload,
    input  logic [31:0]          es_alu_result,
    input  logic                 es_mem_req,
    input  logic                 es_res_from_mem,
    input  logic [2:0]           es_ld_op,
    input  logic                 es_cancel_inc,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 flush,
    input  logic                 ws_allowin,
    output logic                 ms_to_ws_valid,
    output logic [PAYLOAD_W-1:0] ms_payload,
    output logic [31:0]          ms_final_result,
    output logic                 out_ms_valid,
    output logic                 ms_wait_data,
    output logic [31:0]          ms_stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [PAYLOAD_W-1:0]   payload_q, payload_d;
    logic [31:0]            alu_result_q, alu_result_d;
    logic                   res_from_mem_q, res_from_mem_d;
    logic [2:0]             ld_op_q, ld_op_d;
    logic [31:0]            rdata_buf_q, rdata_buf_d;
    logic [CANCEL_W-1:0]    cancel_cnt_q, cancel_cnt_d;

    logic ms_valid;
    logic ms_ready_go;
    logic cancel_zero;
    logic data_hit;
    logic cancel_dec;
    logic flush_orphan;
    logic accept;
    logic retire;

    logic [31:0] mem_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    // data_hit is the current instruction's own response; anything else while cancels are owed is dropped
    always_comb begin
        ms_valid     = (state_q != S_IDLE);
        cancel_zero  = (cancel_cnt_q == '0);
        data_hit     = (state_q == S_WAIT) && data_sram_data_ok && cancel_zero;
        cancel_dec   = data_sram_data_ok && !cancel_zero;
        flush_orphan = flush && (state_q == S_WAIT) && !data_hit;
        ms_ready_go  = (state_q == S_RUN) || (state_q == S_HOLD) || data_hit;
        ms_allowin   = !ms_valid || (ms_ready_go && ws_allowin);
        ms_to_ws_valid = ms_valid && ms_ready_go;
        accept       = es_to_ms_valid && ms_allowin && !flush;
        retire       = ms_to_ws_valid && ws_allowin;
        out_ms_valid = ms_valid;
        ms_wait_data = (state_q == S_WAIT) && ms_valid;
    end

    always_comb begin
        state_d        = state_q;
        payload_d      = payload_q;
        alu_result_d   = alu_result_q;
        res_from_mem_d = res_from_mem_q;
        ld_op_d        = ld_op_q;
        rdata_buf_d    = rdata_buf_q;
        cancel_cnt_d   = cancel_cnt_q + CANCEL_W'(es_cancel_inc) + CANCEL_W'(flush_orphan)
                         - CANCEL_W'(cancel_dec);
        if (flush) begin
            state_d = S_IDLE;
        end else if (accept) begin
            state_d        = es_mem_req ? S_WAIT : S_RUN;
            payload_d      = es_payload;
            alu_result_d   = es_alu_result;
            res_from_mem_d = es_res_from_mem;
            ld_op_d        = es_ld_op;
        end else if (retire) begin
            state_d = S_IDLE;
        end else if (data_hit) begin
            state_d     = S_HOLD;
            rdata_buf_d = data_sram_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= S_IDLE;
            payload_q      <= '0;
            alu_result_q   <= '0;
            res_from_mem_q <= 1'b0;
            ld_op_q        <= '0;
            rdata_buf_q    <= '0;
            cancel_cnt_q   <= '0;
        end else begin
            state_q        <= state_d;
            payload_q      <= payload_d;
            alu_result_q   <= alu_result_d;
            res_from_mem_q <= res_from_mem_d;
            ld_op_q        <= ld_op_d;
            rdata_buf_q    <= rdata_buf_d;
            cancel_cnt_q   <= cancel_cnt_d;
        end
    end

    // Halfword selection only looks at addr[1]; addr[0] is ignored for h/hu
    always_comb begin
        mem_word = (state_q == S_HOLD) ? rdata_buf_q : data_sram_rdata;
        case (alu_result_q[1:0])
            2'd0:    byte_sel = mem_word[7:0];
            2'd1:    byte_sel = mem_word[15:8];
            2'd2:    byte_sel = mem_word[23:16];
            default: byte_sel = mem_word[31:24];
        endcase
        half_sel = alu_result_q[1] ? mem_word[31:16] : mem_word[15:0];
        case (ld_op_q)
            3'd1:    load_data = {{24{byte_sel[7]}}, byte_sel};
            3'd2:    load_data = {24'd0, byte_sel};
            3'd3:    load_data = {{16{half_sel[15]}}, half_sel};
            3'd4:    load_data = {16'd0, half_sel};
            default: load_data = mem_word;
        endcase
        ms_final_result = res_from_mem_q ? load_data : alu_result_q;
        ms_payload      = payload_q;
    end

`ifdef MS_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Cancel-drain cycles in WAIT count as stalls too
    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'((state_q == S_WAIT) && !ms_ready_go);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ms_stall_cnt = stall_cnt_q;
`else
    assign ms_stall_cnt = 32'd0;
`endif

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Parametrised successor of the fixed-latency MEM stage.
- Sits between EXE and WB and talks to a split-transaction data bus (req/addr_ok issued in EXE; data_ok/rdata returned here).
- Stalls until load/store response data arrives and buffers the response if WB is stalled.
- Discards responses owed to flushed instructions, and performs byte/half load extraction with sign/zero extension.

Parameters:
- PAYLOAD_W, 136, width of opaque sideband (pc, dest, gr_we, csr info) passed EXE->WB unchanged.
- CANCEL_W, 2, width of orphaned-response counter (max 2**CANCEL_W-1 outstanding cancels).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- es_to_ms_valid  in  1  EXE holds a valid instruction.
- ms_allowin  out  1  MEM can accept this cycle.
- es_payload  in  PAYLOAD_W  sideband.
- es_alu_result  in  32  ALU result / memory address.
- es_mem_req  in  1  instruction's bus request was accepted (addr_ok seen); MEM must wait for one data_ok.
- es_res_from_mem  in  1  result is load data.
- es_ld_op  in  3  0=w, 1=b, 2=bu, 3=h, 4=hu; 5-7 treated as w.
- es_cancel_inc  in  1  pulse: EXE orphaned one accepted request on flush.
- data_sram_data_ok  in  1  response valid.
- data_sram_rdata  in  32  response data.
- flush  in  1  WB exception/ertn; kills MEM contents.
- ws_allowin  in  1  WB can accept.
- ms_to_ws_valid  out  1  result valid to WB.
- ms_payload  out  PAYLOAD_W  registered sideband.
- ms_final_result  out  32  load data or ALU result.
- out_ms_valid  out  1  ms_valid, for ID hazard logic.
- ms_wait_data  out  1  valid load/store still awaiting data_ok (ID must stall on load-use).
- ms_stall_cnt  out  32  see Optional Feature.

Behaviour:
- Reset (resetn low, async): ms_valid=0, state=IDLE, cancel_cnt=0, buffer empty, ms_stall_cnt=0. All outputs 0 except ms_allowin=1.
- ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
- ms_to_ws_valid = ms_valid & ms_ready_go.
- Accept on es_to_ms_valid & ms_allowin & !flush: latch all es_* inputs.
- States:
  - IDLE: ms_valid=0.
  - RUN: valid, no wait needed.
  - WAIT: valid, es_mem_req latched, no data yet.
  - HOLD: data captured in rdata_buf.
- ms_ready_go = RUN | HOLD | (WAIT & data_ok & cancel_cnt==0).
- Transitions:
  - WAIT, data_ok with cancel_cnt==0: if ws_allowin, retire same cycle; else capture rdata into rdata_buf -> HOLD.
  - Retire with no new accept -> IDLE.
  - Retire with a new accept -> RUN/WAIT per new es_mem_req.
- ms_final_result uses rdata_buf in HOLD, otherwise live data_sram_rdata.
- Extraction by alu_result[1:0]:
  - b/bu: byte sel*8.
  - h/hu: half at sel[1]*16; sel[0] ignored.
  - w: full word.
  - b/h sign-extend; bu/hu zero-extend.
- ms_final_result = res_from_mem ? extracted : alu_result.
- Responses are in order. Any data_ok while cancel_cnt>0 decrements the counter and is dropped, never delivered to the current instruction.
- flush:
  - ms_valid<=0 next cycle, regardless of allowin. No accept in the flush cycle.
  - If state==WAIT and no data_ok arrives that cycle, cancel_cnt += 1, since the response is now orphaned.
  - If data_ok and flush coincide in WAIT with cancel_cnt==0, the data is consumed and no increment occurs.
- Counter update per cycle: cancel_cnt += es_cancel_inc + flush_orphan - (data_ok & cancel_cnt>0). Simultaneous inc and dec net to zero.
- Overflow beyond 2**CANCEL_W-1 is illegal; the bench asserts it never occurs.
- data_ok in IDLE/RUN/HOLD with cancel_cnt==0 is a protocol error; it is ignored.
- ms_wait_data = (state==WAIT) & ms_valid.

Optional Feature:
- MS_PERF_CNT_EN defined: ms_stall_cnt counts cycles with state==WAIT and not ms_ready_go, including cancel-drain cycles. It wraps at 2**32 and is cleared only by reset.
- Undefined: ms_stall_cnt tied to 0 and the counter is not instantiated.

Test Plan:
- ld.b, alu_result=0x1003, rdata=0x80AABBCC, data_ok 3 cycles after accept, ws_allowin=1 -> ms_to_ws_valid 3 cycles later, result 0xFFFFFF80, ms_wait_data high meanwhile.
- ld.hu, addr 0x2002, rdata=0x9ABC1234, data_ok while ws_allowin=0 for 2 cycles -> HOLD, rdata changed to 0 has no effect, result 0x00009ABC on release.
- Load in WAIT, flush asserted -> ms_valid 0 next cycle, cancel_cnt=1. A new ld.w is accepted. The first data_ok(0x11111111) is dropped; the second data_ok(0x22222222) is delivered.
- es_cancel_inc pulse coinciding with a dropping data_ok at cancel_cnt=1 -> cancel_cnt stays 1.
- ALU instruction (es_mem_req=0, alu_result=0x1234) back-to-back with ws_allowin=1 -> one retire per cycle, result 0x1234, zero stall.
- resetn deasserted mid-WAIT -> immediate ms_valid=0, cancel_cnt=0; with MS_PERF_CNT_EN, ms_stall_cnt=0.
